mpt_walk_arbiter: RTL and testbench
===================================

MPT_WALK_ARBITER -- requirements
Module: mpt_walk_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing one MPT walker (range 2..8).
REQ-002 Parameter PLEN, default 34, SHALL set the supervisor physical address width.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 mode_i  input  2  mpt_mode_e from mmpt (MPT_BARE / MPT_34).
REQ-006 flush_i  input  1  abort the in-flight lookup.
REQ-007 req_valid_i  input  NUM_REQ  per-requester lookup request.
REQ-008 req_spa_i  input  NUM_REQ*PLEN  per-requester SPA; slice i is bits [i*PLEN +: PLEN].
REQ-009 req_access_i  input  NUM_REQ*2  per-requester mpt_access_e.
REQ-010 req_ready_o  output  NUM_REQ  one-hot request-accept pulse.
REQ-011 rsp_valid_o  output  NUM_REQ  one-hot response pulse to the accepted requester.
REQ-012 rsp_perm_o  output  2  mpt_permissions_e result.
REQ-013 rsp_fault_o  output  1  lookup faulted (format or access fault).
REQ-014 ptw_valid_o / ptw_ready_i  output/input  1/1  walker start handshake.
REQ-015 ptw_spa_o / ptw_access_o  output  PLEN/2  latched request toward the walker.
REQ-016 ptw_done_i, ptw_perm_i, ptw_fault_i  input  1, 2, 1  walker completion pulse, permissions and fault.
REQ-017 ptw_flush_o  output  1  one-cycle abort pulse to the walker.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, RESPOND and DRAIN.
REQ-020 In IDLE with any req_valid_i set and flush_i low, the block SHALL select the winner: the first valid index at or above rr_q, searching upward modulo NUM_REQ.
REQ-021 In the same IDLE cycle it SHALL pulse req_ready_o[winner], latch the winner's SPA, access type and index, and move to ISSUE (mode MPT_34) or RESPOND (mode MPT_BARE).
REQ-022 In MPT_BARE the response SHALL be ALLOW_RWX with fault 0, and ptw_valid_o SHALL never assert.
REQ-023 In ISSUE, ptw_valid_o SHALL be high with ptw_spa_o/ptw_access_o stable; on ptw_ready_i the FSM SHALL go to WAIT.
REQ-024 flush_i in ISSUE SHALL return the FSM to IDLE with no response and no ptw_flush_o; flush_i takes priority over ptw_ready_i.
REQ-025 In WAIT, ptw_done_i SHALL latch ptw_perm_i/ptw_fault_i and move the FSM to RESPOND.
REQ-026 flush_i in WAIT without ptw_done_i SHALL pulse ptw_flush_o and move the FSM to DRAIN.
REQ-027 flush_i and ptw_done_i in the same WAIT cycle SHALL pulse ptw_flush_o, discard the result and return the FSM to IDLE.
REQ-028 In DRAIN, the FSM SHALL stay until ptw_done_i, discard that result, then go to IDLE; further flush_i in DRAIN SHALL be ignored.
REQ-029 RESPOND SHALL last one cycle: rsp_valid_o[latched index] high, rsp_perm_o/rsp_fault_o valid; then rr_q <= (index+1) mod NUM_REQ and the FSM goes to IDLE.
REQ-030 A faulted lookup SHALL report rsp_perm_o = DISALLOWED.
REQ-031 rr_q SHALL change only in RESPOND; a flushed lookup SHALL leave rr_q unchanged.
REQ-032 Latency in MPT_34: response two cycles after ptw_done_i is sampled in WAIT is NOT allowed; rsp_valid_o SHALL assert the cycle after ptw_done_i.
REQ-033 Latency in MPT_BARE: rsp_valid_o SHALL assert the cycle after req_ready_o.
REQ-034 Requesters SHALL hold req_valid_i until req_ready_o; at most one request SHALL be outstanding at any time.
REQ-035 mode_i SHALL be sampled only in IDLE.

Reset
REQ-036 While rst_i is high, the FSM SHALL be IDLE, rr_q and all latched registers 0, and every output 0 (rsp_perm_o = DISALLOWED).
REQ-037 Reset asserted mid-lookup SHALL drop the lookup with no response and no ptw_flush_o.

Verification
REQ-038 Bench: mode MPT_34, both requesters valid, rr_q=0 -> req_ready_o=01; after ptw_done_i with perm ALLOW_RW, rsp_valid_o=01 and rsp_perm_o=2'b10; next grant req_ready_o=10.
REQ-039 Bench: mode MPT_BARE, req 1 valid with SPA 34'h3_0000_1000 -> req_ready_o=10, then rsp_valid_o=10 with perm 2'b11; ptw_valid_o never high.
REQ-040 Bench: flush_i two cycles into WAIT, ptw_done_i three cycles later -> ptw_flush_o one pulse, no rsp_valid_o, busy_o falls the cycle after ptw_done_i, rr_q unchanged.
REQ-041 Bench: flush_i and ptw_done_i in the same WAIT cycle -> ptw_flush_o pulse, no response, FSM in IDLE the next cycle.
REQ-042 Bench: ptw_fault_i=1 with ptw_done_i -> rsp_fault_o=1 and rsp_perm_o=2'b00.
REQ-043 Bench: rst_i asserted in ISSUE -> all outputs 0 immediately (asynchronously); after release, first grant goes to index 0.

Source files
------------

// File: rtl/mpt_walk_arbiter.sv
// rtl/mpt_walk_arbiter.sv - round-robin arbiter sharing one MPT walker among NUM_REQ requesters
// One lookup in flight; flushes abort it, and a walker already started is drained before reuse.
module mpt_walk_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PLEN    = 34
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              mode_i,
  input  logic                    flush_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*PLEN-1:0] req_spa_i,
  input  logic [NUM_REQ*2-1:0]    req_access_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [1:0]              rsp_perm_o,
  output logic                    rsp_fault_o,
  output logic                    ptw_valid_o,
  input  logic                    ptw_ready_i,
  output logic [PLEN-1:0]         ptw_spa_o,
  output logic [1:0]              ptw_access_o,
  input  logic                    ptw_done_i,
  input  logic [1:0]              ptw_perm_i,
  input  logic                    ptw_fault_i,
  output logic                    ptw_flush_o,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [1:0] MPT_BARE   = 2'b00;
  localparam logic [1:0] PERM_NONE  = 2'b00;
  localparam logic [1:0] PERM_RWX   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND, S_DRAIN} state_e;

  state_e             r_state, w_next;
  logic [IDX_W-1:0]   r_rr, r_idx, w_win, w_hi, w_lo;
  logic               w_hi_f, w_any, w_grant, w_bare;
  logic [PLEN-1:0]    r_spa, w_spa;
  logic [1:0]         r_access, w_acc, r_perm;
  logic               r_fault;

  // Descending scan leaves the lowest valid index; the "hi" pass only counts indices at or above r_rr.
  always_comb begin
    w_hi = '0; w_lo = '0; w_hi_f = 1'b0; w_any = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid_i[j]) begin
        w_lo  = IDX_W'(j);
        w_any = 1'b1;
        if (IDX_W'(j) >= r_rr) begin
          w_hi   = IDX_W'(j);
          w_hi_f = 1'b1;
        end
      end
    end
    w_win = w_hi_f ? w_hi : w_lo;
  end

  always_comb begin
    w_spa = '0; w_acc = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) == w_win) begin
        w_spa = req_spa_i[j*PLEN +: PLEN];
        w_acc = req_access_i[j*2 +: 2];
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_any && !flush_i;
  assign w_bare  = (mode_i == MPT_BARE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_next = w_bare ? S_RESPOND : S_ISSUE;
      S_ISSUE:   if (flush_i) w_next = S_IDLE;
                 else if (ptw_ready_i) w_next = S_WAIT;
      S_WAIT:    if (flush_i) w_next = ptw_done_i ? S_IDLE : S_DRAIN;
                 else if (ptw_done_i) w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      S_DRAIN:   if (ptw_done_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr <= '0; r_idx <= '0; r_spa <= '0; r_access <= '0; r_perm <= '0; r_fault <= 1'b0;
    end else begin
      if (w_grant) begin
        r_idx    <= w_win;
        r_spa    <= w_spa;
        r_access <= w_acc;
        if (w_bare) begin
          r_perm  <= PERM_RWX;
          r_fault <= 1'b0;
        end
      end
      if (r_state == S_WAIT && ptw_done_i && !flush_i) begin
        r_perm  <= ptw_fault_i ? PERM_NONE : ptw_perm_i;
        r_fault <= ptw_fault_i;
      end
      if (r_state == S_RESPOND)
        r_rr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // ptw_valid_o drops under flush so the walker never sees a handshake the FSM is abandoning.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_perm_o  = PERM_NONE;
    rsp_fault_o = 1'b0;
    ptw_valid_o = 1'b0;
    ptw_flush_o = 1'b0;
    busy_o      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (w_grant && !rst_i) req_ready_o = NUM_REQ'(1) << w_win;
      S_ISSUE:   ptw_valid_o = !flush_i;
      S_WAIT:    ptw_flush_o = flush_i;
      S_RESPOND: begin
        rsp_valid_o = NUM_REQ'(1) << r_idx;
        rsp_perm_o  = r_perm;
        rsp_fault_o = r_fault;
      end
      default: ;
    endcase
  end

  assign ptw_spa_o    = r_spa;
  assign ptw_access_o = r_access;

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// tb/tb_mpt_walk_arbiter.sv - table-driven bench for mpt_walk_arbiter
// Inputs driven at negedge; outputs compared 1ns later, well away from the rising edge.
module tb_mpt_walk_arbiter;
  localparam int NUM_REQ = 2;
  localparam int PLEN    = 34;
  localparam logic [1:0] MB = 2'b00;
  localparam logic [1:0] M34 = 2'b01;
  localparam logic [PLEN-1:0] SPA0 = 34'h0_1234_5678;
  localparam logic [PLEN-1:0] SPA1 = 34'h3_0000_1000;
  localparam logic [1:0] ACC0 = 2'b01;
  localparam logic [1:0] ACC1 = 2'b10;

  logic clk = 1'b0;
  logic rst_i;
  logic [1:0] mode_i;
  logic flush_i;
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ*PLEN-1:0] req_spa_i;
  logic [NUM_REQ*2-1:0] req_access_i;
  logic [NUM_REQ-1:0] req_ready_o, rsp_valid_o;
  logic [1:0] rsp_perm_o;
  logic rsp_fault_o, ptw_valid_o, ptw_ready_i;
  logic [PLEN-1:0] ptw_spa_o;
  logic [1:0] ptw_access_o;
  logic ptw_done_i;
  logic [1:0] ptw_perm_i;
  logic ptw_fault_i, ptw_flush_o, busy_o;

  mpt_walk_arbiter #(.NUM_REQ(NUM_REQ), .PLEN(PLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_spa_i(req_spa_i), .req_access_i(req_access_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_perm_o(rsp_perm_o),
    .rsp_fault_o(rsp_fault_o), .ptw_valid_o(ptw_valid_o), .ptw_ready_i(ptw_ready_i),
    .ptw_spa_o(ptw_spa_o), .ptw_access_o(ptw_access_o), .ptw_done_i(ptw_done_i),
    .ptw_perm_i(ptw_perm_i), .ptw_fault_i(ptw_fault_i), .ptw_flush_o(ptw_flush_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [1:0] mode; logic flush; logic [1:0] rv;
    logic prdy; logic pdone; logic [1:0] pperm; logic pfault;
    logic [1:0] e_rdy; logic [1:0] e_rsp; logic [1:0] e_perm; logic e_fault;
    logic e_pv; logic e_pf; logic e_busy;
  } vec_t;

  vec_t vecs[33];
  int n_vec = 0;
  int n_miss = 0;

  function automatic vec_t v(input logic rst, input logic [1:0] mode, input logic flush,
                             input logic [1:0] rv, input logic prdy, input logic pdone,
                             input logic [1:0] pperm, input logic pfault,
                             input logic [1:0] e_rdy, input logic [1:0] e_rsp,
                             input logic [1:0] e_perm, input logic e_fault,
                             input logic e_pv, input logic e_pf, input logic e_busy);
    vec_t r;
    r.rst = rst; r.mode = mode; r.flush = flush; r.rv = rv; r.prdy = prdy; r.pdone = pdone;
    r.pperm = pperm; r.pfault = pfault; r.e_rdy = e_rdy; r.e_rsp = e_rsp; r.e_perm = e_perm;
    r.e_fault = e_fault; r.e_pv = e_pv; r.e_pf = e_pf; r.e_busy = e_busy;
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {req_ready_o, rsp_valid_o, rsp_perm_o, rsp_fault_o, ptw_valid_o, ptw_flush_o, busy_o};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; mode_i = M34; flush_i = 1'b0; req_valid_i = '0;
    req_spa_i = {SPA1, SPA0}; req_access_i = {ACC1, ACC0};
    ptw_ready_i = 1'b0; ptw_done_i = 1'b0; ptw_perm_i = '0; ptw_fault_i = 1'b0;

    //            rst mode flush rv  prdy done perm flt | rdy   rsp   perm  flt pv pf busy
    vecs[0]  = v(1, M34, 0, 2'b11, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[1]  = v(0, M34, 0, 2'b11, 0, 0, 2'b00, 0,   2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[2]  = v(0, M34, 0, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 1, 0, 1);
    vecs[3]  = v(0, M34, 0, 2'b10, 1, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 1, 0, 1);
    vecs[4]  = v(0, M34, 0, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[5]  = v(0, M34, 0, 2'b10, 0, 1, 2'b10, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[6]  = v(0, M34, 0, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b01, 2'b10, 0, 0, 0, 1);
    vecs[7]  = v(0, M34, 0, 2'b11, 0, 0, 2'b00, 0,   2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[8]  = v(0, M34, 0, 2'b00, 1, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 1, 0, 1);
    vecs[9]  = v(0, M34, 0, 2'b00, 0, 1, 2'b11, 1,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[10] = v(0, M34, 0, 2'b00, 0, 0, 2'b00, 0,   2'b00, 2'b10, 2'b00, 1, 0, 0, 1);
    vecs[11] = v(0, MB,  0, 2'b10, 0, 0, 2'b00, 0,   2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[12] = v(0, MB,  0, 2'b00, 1, 0, 2'b00, 0,   2'b00, 2'b10, 2'b11, 0, 0, 0, 1);
    vecs[13] = v(0, M34, 0, 2'b00, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[14] = v(0, M34, 0, 2'b01, 0, 0, 2'b00, 0,   2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[15] = v(0, M34, 1, 2'b00, 1, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[16] = v(0, M34, 0, 2'b11, 0, 0, 2'b00, 0,   2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[17] = v(0, M34, 0, 2'b10, 1, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 1, 0, 1);
    vecs[18] = v(0, M34, 0, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[19] = v(0, M34, 1, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 1, 1);
    vecs[20] = v(0, M34, 1, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[21] = v(0, M34, 0, 2'b10, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[22] = v(0, M34, 0, 2'b10, 0, 1, 2'b10, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[23] = v(0, M34, 0, 2'b11, 0, 0, 2'b00, 0,   2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[24] = v(0, M34, 0, 2'b10, 1, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 1, 0, 1);
    vecs[25] = v(0, M34, 1, 2'b10, 0, 1, 2'b10, 0,   2'b00, 2'b00, 2'b00, 0, 0, 1, 1);
    vecs[26] = v(0, M34, 0, 2'b00, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[27] = v(0, M34, 1, 2'b01, 0, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[28] = v(0, M34, 0, 2'b01, 0, 0, 2'b00, 0,   2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[29] = v(0, M34, 0, 2'b00, 1, 0, 2'b00, 0,   2'b00, 2'b00, 2'b00, 0, 1, 0, 1);
    vecs[30] = v(0, M34, 0, 2'b00, 0, 1, 2'b01, 0,   2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[31] = v(0, M34, 0, 2'b00, 0, 0, 2'b00, 0,   2'b00, 2'b01, 2'b01, 0, 0, 0, 1);
    vecs[32] = v(0, M34, 0, 2'b11, 0, 0, 2'b00, 0,   2'b10, 2'b00, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      rst_i = vecs[i].rst; mode_i = vecs[i].mode; flush_i = vecs[i].flush;
      req_valid_i = vecs[i].rv; ptw_ready_i = vecs[i].prdy; ptw_done_i = vecs[i].pdone;
      ptw_perm_i = vecs[i].pperm; ptw_fault_i = vecs[i].pfault;
      #1;
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].e_rdy, vecs[i].e_rsp, vecs[i].e_perm, vecs[i].e_fault,
                 vecs[i].e_pv, vecs[i].e_pf, vecs[i].e_busy}));
      if (i == 2) check("issue_req0_spa_acc", 64'({ptw_spa_o, ptw_access_o}), 64'({SPA0, ACC0}));
    end

    // Now in ISSUE for requester 1 with rr_q = 1; reset mid-cycle must clear everything at once.
    @(negedge clk);
    req_valid_i = 2'b11; ptw_ready_i = 1'b0; ptw_done_i = 1'b0; flush_i = 1'b0;
    #1;
    check("issue_req1_spa_acc", 64'({ptw_valid_o, busy_o, ptw_spa_o, ptw_access_o}),
          64'({1'b1, 1'b1, SPA1, ACC1}));
    #1;
    rst_i = 1'b1;
    #1;
    check("async_reset_outs", 64'({outs(), ptw_spa_o, ptw_access_o}), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("post_reset_grant0", 64'(outs()), 64'({2'b01, 2'b00, 2'b00, 4'b0000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
